// File: rtl/fp_positn_mul_serial_if.sv
// Handshake/data bundle between the weight-stream loader, the serial FP x posit
// multiplier and the downstream normaliser. The loader side is the master.
interface fp_positn_mul_serial_if #(
  parameter int ACT_WIDTH = 16,
  parameter int MAN_WIDTH = 10,
  parameter int PMAX      = 8,
  parameter int ES        = 1,
  parameter int EXP_OUT_W = 8
);
  localparam int FRAC_MAX = (PMAX - 3 - ES > 0) ? (PMAX - 3 - ES) : 0;
  localparam int PROD_W   = (MAN_WIDTH + 1) + (FRAC_MAX + 1);
  localparam int PREC_W   = $clog2(PMAX + 1);

  logic [ACT_WIDTH-1:0] act;
  logic                 w;
  logic                 valid;
  logic                 set;
  logic [PREC_W-1:0]    precision;
  logic                 out_ready;
  logic                 sign_out;
  logic [EXP_OUT_W-1:0] exp_out;
  logic [PROD_W-1:0]    mantissa_out;
  logic                 zero_out;
  logic                 NaR_out;
  logic                 ovf_out;
  logic                 done;
  logic                 busy;

  modport master (
    output act, w, valid, set, precision, out_ready,
    input  sign_out, exp_out, mantissa_out, zero_out, NaR_out, ovf_out, done, busy
  );

  modport slave (
    input  act, w, valid, set, precision, out_ready,
    output sign_out, exp_out, mantissa_out, zero_out, NaR_out, ovf_out, done, busy
  );
endinterface

// File: rtl/fp_positn_mul_serial.sv
// Serial FP activation x posit weight multiplier (runtime posit precision 2..PMAX).
// The weight is shifted in MSB-first, decoded in one CALC cycle, and the
// unnormalised product is held under a done/out_ready handshake.
// Optional: define FP_POSIT_EXP_SAT_EN to saturate exp_out (and flag ovf_out)
// instead of letting it wrap.
module fp_positn_mul_serial #(
  parameter int ACT_WIDTH = 16,
  parameter int EXP_WIDTH = 5,
  parameter int MAN_WIDTH = 10,
  parameter int PMAX      = 8,
  parameter int ES        = 1,
  parameter int EXP_OUT_W = 8
) (
  input logic                    clk,
  input logic                    rst,
  fp_positn_mul_serial_if.slave  bus
);
  localparam int FRAC_MAX = (PMAX - 3 - ES > 0) ? (PMAX - 3 - ES) : 0;
  localparam int PROD_W   = (MAN_WIDTH + 1) + (FRAC_MAX + 1);
  localparam int PREC_W   = $clog2(PMAX + 1);
  localparam int RW       = PMAX - 1;
  localparam int BIAS     = 2 ** (EXP_WIDTH - 1) - 1;
`ifdef FP_POSIT_EXP_SAT_EN
  localparam int EXP_MAX  = 2 ** (EXP_OUT_W - 1) - 1;
  localparam int EXP_MIN  = -(2 ** (EXP_OUT_W - 1));
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, CALC, DONE} state_t;
  state_t state, state_next;

  logic [PREC_W-1:0]    prec_r, prec_clamp, count, shamt;
  logic [PMAX-1:0]      sr, mask, mag;
  logic [ACT_WIDTH-1:0] act_r;
  logic                 sign_r, zero_r, nar_r, ovf_r;
  logic [EXP_OUT_W-1:0] exp_r;
  logic [PROD_W-1:0]    mant_r;

  logic [RW-1:0]        body, rem;
  logic                 p_sign, p_zero, p_nar, run_bit, run_open;
  int unsigned          run_len, n_body;
  int                   k_val, e_val, exp_full;
  logic [FRAC_MAX:0]    wsig;
  logic                 a_sign, a_zero, a_nar;
  logic [EXP_WIDTH-1:0] a_exp;
  logic [MAN_WIDTH-1:0] a_man;
  logic                 res_sign, res_zero, res_nar, res_ovf;
  logic [EXP_OUT_W-1:0] res_exp;
  logic [PROD_W-1:0]    res_mant;

  // Clamp the requested precision into 2..PMAX
  always_comb begin
    prec_clamp = bus.precision;
    if (bus.precision < PREC_W'(2))         prec_clamp = PREC_W'(2);
    else if (bus.precision > PREC_W'(PMAX)) prec_clamp = PREC_W'(PMAX);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; SHIFT spends one extra cycle noticing count==n
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.valid) state_next = SHIFT;
      SHIFT:   if (count == prec_r) state_next = CALC;
      CALC:    state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Precision, shift register, activation latch and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      prec_r <= PREC_W'(PMAX);
      count  <= '0;
      sr     <= '0;
      act_r  <= '0;
      sign_r <= 1'b0;
      zero_r <= 1'b0;
      nar_r  <= 1'b0;
      ovf_r  <= 1'b0;
      exp_r  <= '0;
      mant_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.set) prec_r <= prec_clamp;
          if (bus.valid) begin
            sr    <= {{(PMAX-1){1'b0}}, bus.w};
            act_r <= bus.act;
            count <= PREC_W'(1);
          end
        end
        SHIFT: begin
          if (count != prec_r && bus.valid) begin
            sr    <= {sr[PMAX-2:0], bus.w};
            count <= count + PREC_W'(1);
          end
        end
        CALC: begin
          sign_r <= res_sign;
          zero_r <= res_zero;
          nar_r  <= res_nar;
          ovf_r  <= res_ovf;
          exp_r  <= res_exp;
          mant_r <= res_mant;
        end
        default: ;
      endcase
    end
  end

  // Posit decode, activation unpack and product formation
  always_comb begin
    // sr holds the word right-aligned with zeros above it, so the sign bit is
    // found by masking rather than a variable bit select.
    shamt  = PREC_W'(PMAX) - prec_r;
    mask   = {PMAX{1'b1}} >> shamt;
    n_body = 32'(prec_r) - 1;
    p_zero = (sr == '0);
    p_nar  = (sr == ({{(PMAX-1){1'b0}}, 1'b1} << (prec_r - PREC_W'(1))));
    p_sign = |(sr & ~(mask >> 1));
    mag    = p_sign ? ((~sr + PMAX'(1)) & mask) : sr;
    body   = RW'(mag << shamt);

    // Regime run is limited to the real body bits, not the zero padding
    run_bit  = body[RW-1];
    run_len  = 0;
    run_open = 1'b1;
    for (int unsigned i = 0; i < RW; i++) begin
      if (run_open && (i < n_body)) begin
        if (body[RW-1-i] == run_bit) run_len = run_len + 1;
        else                         run_open = 1'b0;
      end
    end
    k_val = run_bit ? (int'(run_len) - 1) : -int'(run_len);
    rem   = body << (run_len + 1);

    e_val = 0;
    for (int unsigned j = 0; j < ES; j++) e_val = e_val * 2 + (rem[RW-1-j] ? 1 : 0);
    wsig = '0;
    wsig[FRAC_MAX] = 1'b1;
    for (int unsigned j = 0; j < FRAC_MAX; j++) wsig[FRAC_MAX-1-j] = rem[RW-1-ES-j];

    a_sign = act_r[ACT_WIDTH-1];
    a_exp  = act_r[ACT_WIDTH-2 -: EXP_WIDTH];
    a_man  = act_r[MAN_WIDTH-1:0];
    a_zero = (a_exp == '0);
    a_nar  = (a_exp == '1);

    exp_full = int'(a_exp) - BIAS + k_val * (2 ** ES) + e_val;
    res_mant = PROD_W'({1'b1, a_man}) * PROD_W'(wsig);
    res_sign = a_sign ^ p_sign;
`ifdef FP_POSIT_EXP_SAT_EN
    res_ovf = 1'b0;
    res_exp = EXP_OUT_W'(exp_full);
    if (exp_full > EXP_MAX) begin
      res_exp = EXP_OUT_W'(EXP_MAX);
      res_ovf = 1'b1;
    end else if (exp_full < EXP_MIN) begin
      res_exp = EXP_OUT_W'(EXP_MIN);
      res_ovf = 1'b1;
    end
`else
    res_exp = EXP_OUT_W'(exp_full);
    res_ovf = 1'b0;
`endif

    res_nar  = p_nar | a_nar;
    res_zero = !res_nar && (p_zero || a_zero);
    if (res_nar || res_zero) begin
      res_sign = 1'b0;
      res_exp  = '0;
      res_mant = '0;
      res_ovf  = 1'b0;
    end
  end

  assign bus.sign_out     = sign_r;
  assign bus.exp_out      = exp_r;
  assign bus.mantissa_out = mant_r;
  assign bus.zero_out     = zero_r;
  assign bus.NaR_out      = nar_r;
  assign bus.ovf_out      = ovf_r;
  assign bus.done         = (state == DONE);
  assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_fp_positn_mul_serial.sv
// Directed, table-driven bench for fp_positn_mul_serial (PMAX=8, ES=1, FP16).
module tb_fp_positn_mul_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  fp_positn_mul_serial_if #(
    .ACT_WIDTH(16), .MAN_WIDTH(10), .PMAX(8), .ES(1), .EXP_OUT_W(8)
  ) bus ();

  fp_positn_mul_serial #(
    .ACT_WIDTH(16), .EXP_WIDTH(5), .MAN_WIDTH(10), .PMAX(8), .ES(1), .EXP_OUT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int unsigned prec;
    logic        set_en;
    logic [15:0] act;
    logic [7:0]  word;
    int unsigned stall_after;
    int unsigned hold;
    logic        sign;
    logic [7:0]  exp;
    logic [15:0] mant;
    logic        zero;
    logic        nar;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prec(input logic [3:0] p);
    bus.valid     = 1'b0;
    bus.set       = 1'b1;
    bus.precision = p;
    tick();
    bus.set = 1'b0;
  endtask

  task automatic check_fields(input string tag, input vec_t v);
    chk({tag, " sign"}, 32'(bus.sign_out), 32'(v.sign));
    chk({tag, " exp"},  32'(bus.exp_out), 32'(v.exp));
    chk({tag, " mant"}, 32'(bus.mantissa_out), 32'(v.mant));
    chk({tag, " zero"}, 32'(bus.zero_out), 32'(v.zero));
    chk({tag, " nar"},  32'(bus.NaR_out), 32'(v.nar));
    chk({tag, " ovf"},  32'(bus.ovf_out), 32'(0));
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [7:0] wd;
    wd = v.word;
    for (int i = int'(v.prec) - 1; i >= 0; i--) begin
      bus.valid = 1'b1;
      bus.w     = wd[i];
      if (i == int'(v.prec) - 1) begin
        bus.act       = v.act;
        bus.set       = v.set_en;
        bus.precision = v.set_en ? 4'(v.prec) : 4'd3;
      end
      tick();
      bus.set = 1'b0;
      bus.act = 16'($urandom);
      if (v.stall_after != 0 && (int'(v.prec) - i) == int'(v.stall_after) && i != 0) begin
        for (int s = 0; s < 2; s++) begin
          bus.valid     = 1'b0;
          bus.w         = 1'($urandom);
          bus.set       = 1'b1;
          bus.precision = 4'd2;
          tick();
        end
        bus.set = 1'b0;
      end
    end
    bus.valid = 1'b0;
    chk({tag, " busy t+0"}, 32'(bus.busy), 32'(1));
    tick();
    chk({tag, " done t+1"}, 32'(bus.done), 32'(0));
    tick();
    chk({tag, " done t+2"}, 32'(bus.done), 32'(1));
    check_fields(tag, v);
    for (int h = 0; h < int'(v.hold); h++) begin
      bus.out_ready = 1'b0;
      bus.valid     = 1'($urandom);
      bus.w         = 1'($urandom);
      tick();
      chk({tag, " hold done"}, 32'(bus.done), 32'(1));
      chk({tag, " hold exp"},  32'(bus.exp_out), 32'(v.exp));
      chk({tag, " hold mant"}, 32'(bus.mantissa_out), 32'(v.mant));
    end
    bus.valid     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, " release done"}, 32'(bus.done), 32'(0));
    chk({tag, " release busy"}, 32'(bus.busy), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //          prec set act       word  stl hold sign exp    mant      zero nar
    vecs[0]  = '{8, 1'b1, 16'h3C00, 8'h40, 0, 0, 1'b0, 8'h00, 16'h4000, 1'b0, 1'b0};
    vecs[1]  = '{8, 1'b1, 16'hC000, 8'h60, 0, 0, 1'b1, 8'h03, 16'h4000, 1'b0, 1'b0};
    vecs[2]  = '{8, 1'b1, 16'h3E00, 8'hC0, 0, 0, 1'b1, 8'h00, 16'h6000, 1'b0, 1'b0};
    vecs[3]  = '{8, 1'b1, 16'h3C00, 8'h5B, 0, 0, 1'b0, 8'h01, 16'h6C00, 1'b0, 1'b0};
    vecs[4]  = '{8, 1'b1, 16'h3C00, 8'h12, 0, 0, 1'b0, 8'hFC, 16'h5000, 1'b0, 1'b0};
    vecs[5]  = '{8, 1'b1, 16'h7800, 8'h7F, 0, 0, 1'b0, 8'h1B, 16'h4000, 1'b0, 1'b0};
    vecs[6]  = '{8, 1'b1, 16'h0400, 8'h01, 0, 0, 1'b0, 8'hE6, 16'h4000, 1'b0, 1'b0};
    vecs[7]  = '{8, 1'b1, 16'h3D00, 8'h5B, 0, 0, 1'b0, 8'h01, 16'h8700, 1'b0, 1'b0};
    vecs[8]  = '{8, 1'b1, 16'h3C00, 8'hA5, 0, 0, 1'b1, 8'h01, 16'h6C00, 1'b0, 1'b0};
    vecs[9]  = '{8, 1'b1, 16'h3C00, 8'h80, 0, 0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{8, 1'b1, 16'h0000, 8'h40, 0, 0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{8, 1'b1, 16'h0123, 8'h40, 0, 0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0};
    vecs[12] = '{8, 1'b1, 16'h0000, 8'h80, 0, 0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1};
    vecs[13] = '{8, 1'b1, 16'h7C00, 8'h00, 0, 0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1};
    vecs[14] = '{4, 1'b1, 16'h3C00, 8'h00, 2, 0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0};
    vecs[15] = '{4, 1'b1, 16'h3C00, 8'h08, 0, 0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1};
    vecs[16] = '{4, 1'b1, 16'h7C00, 8'h04, 0, 0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1};
    vecs[17] = '{4, 1'b1, 16'h3C00, 8'h07, 0, 0, 1'b0, 8'h04, 16'h4000, 1'b0, 1'b0};
    vecs[18] = '{4, 1'b1, 16'h3C00, 8'h03, 0, 0, 1'b0, 8'hFF, 16'h4000, 1'b0, 1'b0};
    vecs[19] = '{4, 1'b1, 16'h3C00, 8'h0C, 0, 0, 1'b1, 8'h00, 16'h4000, 1'b0, 1'b0};
    vecs[20] = '{5, 1'b1, 16'h3C00, 8'h0B, 0, 0, 1'b0, 8'h01, 16'h6000, 1'b0, 1'b0};
    vecs[21] = '{2, 1'b1, 16'h3C00, 8'h01, 0, 0, 1'b0, 8'h00, 16'h4000, 1'b0, 1'b0};
    vecs[22] = '{2, 1'b1, 16'hBC00, 8'h03, 0, 0, 1'b0, 8'h00, 16'h4000, 1'b0, 1'b0};
    vecs[23] = '{8, 1'b1, 16'hC000, 8'h60, 5, 3, 1'b1, 8'h03, 16'h4000, 1'b0, 1'b0};

    bus.act = '0; bus.w = 1'b0; bus.valid = 1'b0; bus.set = 1'b0;
    bus.precision = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst busy", 32'(bus.busy), 32'(0));
    chk("rst done", 32'(bus.done), 32'(0));
    v = '{8, 1'b0, 16'h0, 8'h0, 0, 0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0};
    check_fields("rst", v);

    for (int i = 0; i < 24; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Explicit set cycle before a 4-bit word with a mid-word stall
    set_prec(4'd4);
    v = '{4, 1'b0, 16'h3C00, 8'h00, 2, 0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0};
    run_vec("prec4 stall", v);

    // Reset in the middle of a word restores precision to PMAX
    set_prec(4'd4);
    bus.act = 16'h3C00;
    for (int i = 0; i < 3; i++) begin
      bus.valid = 1'b1;
      bus.w     = 1'($urandom);
      tick();
    end
    bus.valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst busy", 32'(bus.busy), 32'(0));
    chk("midrst done", 32'(bus.done), 32'(0));
    v = '{8, 1'b0, 16'h0, 8'h0, 0, 0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0};
    check_fields("midrst", v);
    v = '{8, 1'b0, 16'hC000, 8'h60, 0, 0, 1'b1, 8'h03, 16'h4000, 1'b0, 1'b0};
    run_vec("post rst", v);

    // Clamping of out-of-range precision requests
    set_prec(4'd9);
    v = '{8, 1'b0, 16'h3C00, 8'h5B, 0, 0, 1'b0, 8'h01, 16'h6C00, 1'b0, 1'b0};
    run_vec("clamp9", v);
    set_prec(4'd0);
    v = '{2, 1'b0, 16'hBC00, 8'h03, 0, 0, 1'b0, 8'h00, 16'h4000, 1'b0, 1'b0};
    run_vec("clamp0", v);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fp_positn_mul_serial.md
Name: fp_positn_mul_serial

Overview:
Generalised successor to the 4-bit serial FP16×posit multiplier. Multiplies one FP activation by a posit weight of runtime precision 2..PMAX with ES exponent bits. The weight arrives bit-serially MSB-first, is decoded after the last bit, and the product is returned unnormalised. Sits between the weight-stream loader and the downstream normaliser/accumulator, and adds a ready/done output handshake.

Parameters:
ACT_WIDTH, 16, activation width; must equal 1+EXP_WIDTH+MAN_WIDTH
EXP_WIDTH, 5, activation exponent field width; bias = 2^(EXP_WIDTH-1)-1
MAN_WIDTH, 10, activation mantissa field width
PMAX, 8, maximum posit precision in bits (>=3)
ES, 1, posit exponent bits
EXP_OUT_W, 8, signed output exponent width
(derived) FRAC_MAX = max(PMAX-3-ES, 0); PROD_W = (MAN_WIDTH+1)+(FRAC_MAX+1)

Ports:
clk  in  1  clock
rst  in  1  reset
act  in  ACT_WIDTH  FP activation; sampled with the first weight bit
w  in  1  serial posit weight bit, MSB first
valid  in  1  w is valid this cycle
set  in  1  load precision (IDLE only)
precision  in  clog2(PMAX+1)  posit width n
out_ready  in  1  consumer accepts the result
sign_out  out  1  product sign
exp_out  out  EXP_OUT_W  signed unbiased product exponent
mantissa_out  out  PROD_W  significand product; binary point below the top 2 bits
zero_out  out  1  result is zero
NaR_out  out  1  result is NaR
ovf_out  out  1  exponent saturated (feature only)
done  out  1  result valid; held until accepted
busy  out  1  state != IDLE

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (any state, including mid-word): state=IDLE; all outputs 0; precision register = PMAX; bit counter = 0.
- FSM states:
  - IDLE: set=1 loads the precision register. Values below 2 clamp to 2; values above PMAX clamp to PMAX. If valid=1 in the same cycle, set applies first and the new precision governs this word. On valid=1: shift in w, latch act, count=1, go to SHIFT (go directly to CALC if n would be 1; cannot occur after clamp).
  - SHIFT: valid=1 shifts in w and increments count. valid=0 stalls; count and shift register hold. set and act changes are ignored. When count reaches n, go to CALC.
  - CALC: one cycle. Decode and multiply; register results; go to DONE.
  - DONE: done=1 and outputs stable. When out_ready=1: go to IDLE and clear done next cycle. w/valid are ignored in DONE.
- Latency: last bit sampled at edge t; CALC at t+1; done=1 visible after edge t+2.
- Posit decode (n-bit word W):
  - W==0 → zero.
  - W==1 followed by n-1 zeros → NaR.
  - If the MSB is 1, negate W in two's complement over n bits; posit sign = 1.
  - Left-align the remaining n-1 bits to PMAX-1.
  - Regime: run of identical bits r, terminated by the opposite bit or the end of word. k = r-1 if the run is 1s, else -r.
  - Next ES bits form e. Bits missing past the end of the word count as 0.
  - Remaining bits form the fraction, left-aligned into FRAC_MAX bits with zero padding. Extra bits beyond FRAC_MAX are truncated.
- Activation: exponent field 0 → zero (subnormals flushed). Exponent field all ones → NaR.
- Result fields:
  - sign_out = act sign XOR posit sign.
  - exp_out = (act_exp - bias) + k·2^ES + e, computed at full width, then truncated to EXP_OUT_W (two's-complement wrap).
  - mantissa_out = {1,act_man} × {1,frac}, unsigned, PROD_W bits.
- Specials: NaR has priority over zero. On either, sign_out, exp_out and mantissa_out are 0.

Optional Feature:
FP_POSIT_EXP_SAT_EN.
- Defined: exp_out saturates to the signed EXP_OUT_W max/min instead of wrapping, and ovf_out=1 with that result. ovf_out is 0 on zero/NaR.
- Undefined: exp_out wraps and ovf_out is tied to 0.

Test Plan:
1. PMAX=8, ES=1, prec 8, act 0x3C00, w=0x40 → done 2 cycles after the last bit: sign 0, exp 0, mantissa 16'h4000, zero/NaR 0.
2. act 0xC000, w=0x60 → sign 1, exp 3, mantissa 16'h4000.
3. act 0x3E00, w=0xC0 (negative posit) → sign 1, exp 0, mantissa 16'h6000.
4. set with prec 4, then w=0000 with valid deasserted 2 cycles mid-word → zero_out=1, other fields 0. Then w=1000 → NaR_out=1. Then act 0x7C00 with w=0100 → NaR_out=1.
5. out_ready held low 3 cycles after done → done and outputs stable 3 cycles; valid/w toggling ignored. Assert out_ready → IDLE next cycle, done=0.
6. rst pulsed after 3 of 8 bits → all outputs 0, busy=0, precision=PMAX. A fresh full word then yields the correct result. set=9 → clamped to 8. set=0 → clamped to 2.
